round_controller: RTL and testbench
===================================

# round_controller

Game-sequencing FSM of the electronic Mastermind machine; the consumer of the start-state handshake. Once the start FSM reports `started`, this block takes over:
- lets the code-setting player load a secret code;
- hands turns to the guessing player;
- judges each guess from the scorer's exact-match count;
- awards round points and swaps roles each round, until one player reaches the winning score.

## Interface
Parameters:
- MAX_GUESSES, 7: guesses allowed per round (1..7).
- ROUNDS_TO_WIN, 2: round points that end the game (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- started  in  1  level; high once the start FSM has chosen the first player.
- first_p  in  1  first code setter (1 = A, 0 = B); valid while `started` is high.
- enterA  in  1  player A enter key; synchronous level.
- enterB  in  1  player B enter key; synchronous level.
- exact  in  3  exact-position matches (0..4) from the scorer; valid in the cycle after a `load_guess` pulse.
- load_code  out  1  one-cycle strobe: code register captures the switches.
- load_guess  out  1  one-cycle strobe: guess register captures the switches.
- active_p  out  1  player whose enter key is accepted (1 = A).
- guess_count  out  3  misses so far in the current round.
- scoreA  out  2  round points for A.
- scoreB  out  2  round points for B.
- round_over  out  1  high while in ROUND_END.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  game winner (1 = A); meaningful only while `game_over` is high.

## Operation
Edge detect:
- enterA_d and enterB_d are registered copies of the keys; they reset to 1.
- riseX = enterX & ~enterX_d. A key held through reset release never fires.

setter register:
- Holds the current code setter (1 = A).
- Loaded from first_p on the IDLE->CODE transition.
- Inverted on every ROUND_END->CODE transition.

States and transitions:
- IDLE: waits for started=1, then -> CODE.
- CODE: active_p = setter. On the setter's rise: load_code pulses, guess_count <= 0, -> GUESS.
- GUESS: active_p = ~setter. On the guesser's rise: load_guess pulses, -> LOAD.
- LOAD: one cycle while the scorer updates, -> CHECK.
- CHECK: one cycle. Samples exact at the closing edge:
  - exact==4: guesser's score += 1, -> ROUND_END.
  - else if guess_count+1 == MAX_GUESSES: setter's score += 1, guess_count <= MAX_GUESSES, -> ROUND_END.
  - else: guess_count += 1, -> GUESS.
- ROUND_END: round_over=1.
  - If scoreA or scoreB == ROUNDS_TO_WIN: -> GAME_OVER next cycle, with no key needed.
  - Otherwise a rise on either key -> CODE with roles swapped.
- GAME_OVER: game_over=1; winner = (scoreA == ROUNDS_TO_WIN). Holds until reset.

Input filtering:
- A rise from the non-active player is ignored in CODE and GUESS.
- Simultaneous rises: only the active player's rise counts; in ROUND_END either rise suffices.
- Keys are ignored in IDLE, LOAD, CHECK and GAME_OVER.

Other rules:
- Scores saturate and never exceed ROUNDS_TO_WIN.
- exact values 5..7 are treated as a miss.
- active_p is 0 in IDLE, LOAD, CHECK, ROUND_END and GAME_OVER.

## Timing
- Reset (asynchronous):
  - state = IDLE, setter = 0.
  - All outputs 0: load_code, load_guess, active_p, guess_count, scoreA, scoreB, round_over, game_over, winner.
  - enterA_d and enterB_d = 1.
- Reset asserted mid-game returns everything to the reset values immediately. Strobes do not complete.
- All outputs are registered or state-decoded; no combinational path from a key to a strobe.
- If a rise is seen at posedge t, the strobe (`load_code` or `load_guess`) is high for exactly the cycle t..t+1.
- Guess latency: LOAD occupies t..t+1, CHECK occupies t+1..t+2. The verdict is registered at posedge t+2.
- guess_count and score updates are visible the cycle after CHECK.
- A key must fall and rise again to make another entry. Holding a key produces one entry only.

## Test plan
- Reset release with enterA held high, started=1, first_p=1 -> state goes to CODE with active_p=1; no load_code pulse until enterA falls and rises again.
- In CODE with setter A, pulse enterB, then enterA -> enterB ignored; exactly one load_code pulse, then active_p=0 (GUESS).
- Guess with exact=4 -> load_guess pulse; two cycles later scoreB=1, round_over=1, guess_count=0.
- Seven guesses with exact=2 (MAX_GUESSES=7) -> guess_count steps 1..6 and ends at 7; scoreA=1; round_over=1.
- ROUNDS_TO_WIN=2; B wins two rounds with roles alternating -> after round 1, a key rise gives CODE with setter=B (active_p=0); after round 2, game_over=1, winner=0, scoreB=2; further keys have no effect.
- Assert reset during LOAD -> all outputs 0 and state IDLE in the same cycle; no CHECK update occurs.

Source files
------------

// File: rtl/round_controller_if.sv
// Game bus of the Mastermind round controller: player keys, start-FSM
// handshake and scorer result in; strobes, turn and score status out.
interface round_controller_if;
    logic       started;
    logic       first_p;
    logic       enterA;
    logic       enterB;
    logic [2:0] exact;
    logic       load_code;
    logic       load_guess;
    logic       active_p;
    logic [2:0] guess_count;
    logic [1:0] scoreA;
    logic [1:0] scoreB;
    logic       round_over;
    logic       game_over;
    logic       winner;

    modport master (
        input  started, first_p, enterA, enterB, exact,
        output load_code, load_guess, active_p, guess_count,
               scoreA, scoreB, round_over, game_over, winner
    );

    modport slave (
        output started, first_p, enterA, enterB, exact,
        input  load_code, load_guess, active_p, guess_count,
               scoreA, scoreB, round_over, game_over, winner
    );
endinterface

// File: rtl/round_controller.sv
// Round sequencing for the Mastermind machine: code entry, guess turns,
// verdicts from the scorer's exact count, round points and role swaps.
module round_controller #(
    parameter int unsigned MAX_GUESSES   = 7,
    parameter int unsigned ROUNDS_TO_WIN = 2
) (
    input  logic               clk,
    input  logic               reset,
    round_controller_if.master bus
);

    localparam logic [2:0] MAX_G = 3'(MAX_GUESSES);
    localparam logic [1:0] WIN   = 2'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_GUESS,
        S_LOAD,
        S_CHECK,
        S_ROUND_END,
        S_GAME_OVER
    } state_t;

    state_t     state_q, state_d;
    logic       setter_q, setter_d;
    logic       enter_a_q, enter_a_d;
    logic       enter_b_q, enter_b_d;
    logic       load_code_q, load_code_d;
    logic       load_guess_q, load_guess_d;
    logic [2:0] guess_count_q, guess_count_d;
    logic [1:0] score_a_q, score_a_d;
    logic [1:0] score_b_q, score_b_d;
    logic       rise_a, rise_b;

    // State, key history, strobes and counters; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            setter_q      <= 1'b0;
            enter_a_q     <= 1'b1;
            enter_b_q     <= 1'b1;
            load_code_q   <= 1'b0;
            load_guess_q  <= 1'b0;
            guess_count_q <= '0;
            score_a_q     <= '0;
            score_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            setter_q      <= setter_d;
            enter_a_q     <= enter_a_d;
            enter_b_q     <= enter_b_d;
            load_code_q   <= load_code_d;
            load_guess_q  <= load_guess_d;
            guess_count_q <= guess_count_d;
            score_a_q     <= score_a_d;
            score_b_q     <= score_b_d;
        end
    end

    // Next-state, strobe and score logic driven by key rising edges.
    always_comb begin
        state_d       = state_q;
        setter_d      = setter_q;
        enter_a_d     = bus.enterA;
        enter_b_d     = bus.enterB;
        load_code_d   = 1'b0;
        load_guess_d  = 1'b0;
        guess_count_d = guess_count_q;
        score_a_d     = score_a_q;
        score_b_d     = score_b_q;
        rise_a        = bus.enterA & ~enter_a_q;
        rise_b        = bus.enterB & ~enter_b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.started) begin
                    setter_d = bus.first_p;
                    state_d  = S_CODE;
                end
            end
            S_CODE: begin
                if (setter_q ? rise_a : rise_b) begin
                    load_code_d   = 1'b1;
                    guess_count_d = '0;
                    state_d       = S_GUESS;
                end
            end
            S_GUESS: begin
                if (setter_q ? rise_b : rise_a) begin
                    load_guess_d = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.exact == 3'd4) begin
                    // Guesser is the player opposite the setter.
                    if (setter_q) begin
                        if (score_b_q != WIN) score_b_d = score_b_q + 2'd1;
                    end else begin
                        if (score_a_q != WIN) score_a_d = score_a_q + 2'd1;
                    end
                    state_d = S_ROUND_END;
                end else if (guess_count_q + 3'd1 == MAX_G) begin
                    if (setter_q) begin
                        if (score_a_q != WIN) score_a_d = score_a_q + 2'd1;
                    end else begin
                        if (score_b_q != WIN) score_b_d = score_b_q + 2'd1;
                    end
                    guess_count_d = MAX_G;
                    state_d       = S_ROUND_END;
                end else begin
                    guess_count_d = guess_count_q + 3'd1;
                    state_d       = S_GUESS;
                end
            end
            S_ROUND_END: begin
                if (score_a_q == WIN || score_b_q == WIN) begin
                    state_d = S_GAME_OVER;
                end else if (rise_a | rise_b) begin
                    setter_d = ~setter_q;
                    state_d  = S_CODE;
                end
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are flops or pure state decodes; keys never reach them combinationally.
    always_comb begin
        bus.load_code   = load_code_q;
        bus.load_guess  = load_guess_q;
        bus.guess_count = guess_count_q;
        bus.scoreA      = score_a_q;
        bus.scoreB      = score_b_q;
        bus.round_over  = (state_q == S_ROUND_END);
        bus.game_over   = (state_q == S_GAME_OVER);
        bus.winner      = (state_q == S_GAME_OVER) && (score_a_q == WIN);
        bus.active_p    = 1'b0;
        if (state_q == S_CODE)  bus.active_p = setter_q;
        if (state_q == S_GUESS) bus.active_p = ~setter_q;
    end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios plus randomized games
// checked against a game-level score model.
module tb_round_controller;

    localparam int MAXG = 7;
    localparam int RTW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    round_controller_if bus();

    round_controller #(.MAX_GUESSES(MAXG), .ROUNDS_TO_WIN(RTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: who sets the code, points per player (index 1 = A), misses.
    logic m_setter;
    int   m_score[2];
    int   m_misses;

    // Drive keys for one cycle starting at a negedge; returns at next negedge
    // with keys released.
    task automatic press(input logic a, input logic b);
        bus.enterA = a;
        bus.enterB = b;
        @(negedge clk);
        bus.enterA = 1'b0;
        bus.enterB = 1'b0;
    endtask

    task automatic init_game(input logic fp);
        @(negedge clk);
        reset       = 1'b0;
        bus.enterA  = 1'b0;
        bus.enterB  = 1'b0;
        bus.started = 1'b0;
        bus.exact   = 3'd0;
        #1;
        n_checks++;
        if ({bus.load_code, bus.load_guess, bus.active_p, bus.guess_count, bus.scoreA,
             bus.scoreB, bus.round_over, bus.game_over, bus.winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lc=%b lg=%b ap=%b gc=%0d sA=%0d sB=%0d ro=%b go=%b w=%b, required all 0",
                     bus.load_code, bus.load_guess, bus.active_p, bus.guess_count, bus.scoreA,
                     bus.scoreB, bus.round_over, bus.game_over, bus.winner);
        end
        @(negedge clk);
        reset       = 1'b1;
        bus.started = 1'b1;
        bus.first_p = fp;
        @(negedge clk);
        n_checks++;
        if (bus.active_p !== fp) begin
            n_fail++;
            $display("FAIL start_code_turn: active_p got %b required %b", bus.active_p, fp);
        end
        m_setter = fp;
        m_score[0] = 0;
        m_score[1] = 0;
        m_misses = 0;
    endtask

    task automatic code_phase();
        logic both;
        if ($urandom_range(0, 1) == 1) begin
            press(~m_setter, m_setter);
            n_checks++;
            if (bus.load_code !== 1'b0 || bus.active_p !== m_setter) begin
                n_fail++;
                $display("FAIL code_ignore_other: lc=%b ap=%b, required lc=0 ap=%b",
                         bus.load_code, bus.active_p, m_setter);
            end
            @(negedge clk);
        end
        both = 1'($urandom_range(0, 1));
        press(m_setter | both, ~m_setter | both);
        n_checks++;
        if (bus.load_code !== 1'b1 || bus.active_p !== ~m_setter || bus.guess_count !== 3'd0) begin
            n_fail++;
            $display("FAIL code_entry: lc=%b ap=%b gc=%0d, required lc=1 ap=%b gc=0",
                     bus.load_code, bus.active_p, bus.guess_count, ~m_setter);
        end
        m_misses = 0;
        @(negedge clk);
        n_checks++;
        if (bus.load_code !== 1'b0) begin
            n_fail++;
            $display("FAIL code_strobe_width: load_code got %b required 0", bus.load_code);
        end
    endtask

    task automatic guess_phase(input logic [2:0] ex, output bit round_done);
        logic guesser;
        logic [2:0] garbage;
        int exp_round;
        guesser = ~m_setter;
        if ($urandom_range(0, 1) == 1) begin
            press(m_setter, ~m_setter);
            n_checks++;
            if (bus.load_guess !== 1'b0 || bus.active_p !== guesser) begin
                n_fail++;
                $display("FAIL guess_ignore_other: lg=%b ap=%b, required lg=0 ap=%b",
                         bus.load_guess, bus.active_p, guesser);
            end
            @(negedge clk);
        end
        press(guesser, ~guesser);
        n_checks++;
        if (bus.load_guess !== 1'b1 || bus.active_p !== 1'b0) begin
            n_fail++;
            $display("FAIL guess_entry: lg=%b ap=%b, required lg=1 ap=0", bus.load_guess, bus.active_p);
        end
        garbage    = ex ^ 3'($urandom_range(1, 7));
        bus.exact  = garbage;
        bus.enterA = 1'($urandom_range(0, 1));
        bus.enterB = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.enterA = 1'b0;
        bus.enterB = 1'b0;
        bus.exact  = ex;
        n_checks++;
        if (bus.load_guess !== 1'b0 || bus.active_p !== 1'b0 ||
            bus.guess_count !== 3'(m_misses) || bus.round_over !== 1'b0) begin
            n_fail++;
            $display("FAIL check_cycle: lg=%b ap=%b gc=%0d ro=%b, required lg=0 ap=0 gc=%0d ro=0",
                     bus.load_guess, bus.active_p, bus.guess_count, bus.round_over, m_misses);
        end
        @(negedge clk);
        exp_round = 0;
        if (ex == 3'd4) begin
            if (m_score[int'(guesser)] < RTW) m_score[int'(guesser)]++;
            exp_round = 1;
        end else begin
            m_misses++;
            if (m_misses == MAXG) begin
                if (m_score[int'(m_setter)] < RTW) m_score[int'(m_setter)]++;
                exp_round = 1;
            end
        end
        n_checks++;
        if (bus.guess_count !== 3'(m_misses) || bus.scoreA !== 2'(m_score[1]) ||
            bus.scoreB !== 2'(m_score[0]) || bus.round_over !== 1'(exp_round) ||
            bus.active_p !== (exp_round == 1 ? 1'b0 : guesser)) begin
            n_fail++;
            $display("FAIL verdict(exact=%0d): gc=%0d sA=%0d sB=%0d ro=%b ap=%b, required gc=%0d sA=%0d sB=%0d ro=%0d ap=%b",
                     ex, bus.guess_count, bus.scoreA, bus.scoreB, bus.round_over, bus.active_p,
                     m_misses, m_score[1], m_score[0], exp_round,
                     (exp_round == 1 ? 1'b0 : guesser));
        end
        round_done = (exp_round == 1);
    endtask

    task automatic round_end_phase(output bit game_done);
        int k;
        if (m_score[0] == RTW || m_score[1] == RTW) begin
            @(negedge clk);
            n_checks++;
            if (bus.game_over !== 1'b1 || bus.round_over !== 1'b0 ||
                bus.winner !== (m_score[1] == RTW)) begin
                n_fail++;
                $display("FAIL game_over_entry: go=%b ro=%b w=%b, required go=1 ro=0 w=%b",
                         bus.game_over, bus.round_over, bus.winner, (m_score[1] == RTW));
            end
            press(1'b1, 1'b1);
            @(negedge clk);
            n_checks++;
            if (bus.game_over !== 1'b1 || bus.load_code !== 1'b0 || bus.active_p !== 1'b0 ||
                bus.scoreA !== 2'(m_score[1]) || bus.scoreB !== 2'(m_score[0])) begin
                n_fail++;
                $display("FAIL game_over_hold: go=%b lc=%b ap=%b sA=%0d sB=%0d, required go=1 lc=0 ap=0 sA=%0d sB=%0d",
                         bus.game_over, bus.load_code, bus.active_p, bus.scoreA, bus.scoreB,
                         m_score[1], m_score[0]);
            end
            game_done = 1'b1;
        end else begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                n_checks++;
                if (bus.round_over !== 1'b1 || bus.active_p !== 1'b0) begin
                    n_fail++;
                    $display("FAIL round_end_wait: ro=%b ap=%b, required ro=1 ap=0",
                             bus.round_over, bus.active_p);
                end
            end
            k = $urandom_range(1, 3);
            press(k[1], k[0]);
            m_setter = ~m_setter;
            n_checks++;
            if (bus.round_over !== 1'b0 || bus.active_p !== m_setter || bus.load_code !== 1'b0) begin
                n_fail++;
                $display("FAIL role_swap: ro=%b ap=%b lc=%b, required ro=0 ap=%b lc=0",
                         bus.round_over, bus.active_p, bus.load_code, m_setter);
            end
            @(negedge clk);
            game_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bus.enterA  = 1'b1;
        bus.enterB  = 1'b0;
        bus.started = 1'b1;
        bus.first_p = 1'b1;
        bus.exact   = 3'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.load_code, bus.load_guess, bus.active_p, bus.guess_count, bus.scoreA,
             bus.scoreB, bus.round_over, bus.game_over, bus.winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all 0 (lc=%b ap=%b gc=%0d)",
                     bus.load_code, bus.active_p, bus.guess_count);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bus.active_p !== 1'b1 || bus.load_code !== 1'b0) begin
                n_fail++;
                $display("FAIL held_key_release: ap=%b lc=%b, required ap=1 lc=0",
                         bus.active_p, bus.load_code);
            end
        end
        bus.enterA = 1'b0;
        @(negedge clk);
        press(1'b0, 1'b1);
        n_checks++;
        if (bus.load_code !== 1'b0 || bus.active_p !== 1'b1) begin
            n_fail++;
            $display("FAIL b_ignored_in_code: lc=%b ap=%b, required lc=0 ap=1", bus.load_code, bus.active_p);
        end
        @(negedge clk);
        press(1'b1, 1'b0);
        n_checks++;
        if (bus.load_code !== 1'b1 || bus.active_p !== 1'b0) begin
            n_fail++;
            $display("FAIL a_code_entry: lc=%b ap=%b, required lc=1 ap=0", bus.load_code, bus.active_p);
        end
        @(negedge clk);
        n_checks++;
        if (bus.load_code !== 1'b0) begin
            n_fail++;
            $display("FAIL single_load_code: lc=%b required 0", bus.load_code);
        end
    endtask

    task automatic test_hit();
        bit rd;
        init_game(1'b1);
        code_phase();
        guess_phase(3'd4, rd);
        n_checks++;
        if (bus.scoreB !== 2'd1 || bus.round_over !== 1'b1 || bus.guess_count !== 3'd0) begin
            n_fail++;
            $display("FAIL first_guess_hit: sB=%0d ro=%b gc=%0d, required sB=1 ro=1 gc=0",
                     bus.scoreB, bus.round_over, bus.guess_count);
        end
    endtask

    task automatic test_max_misses();
        bit rd;
        init_game(1'b1);
        code_phase();
        for (int i = 0; i < MAXG; i++) guess_phase(3'd2, rd);
        n_checks++;
        if (bus.guess_count !== 3'd7 || bus.scoreA !== 2'd1 || bus.round_over !== 1'b1) begin
            n_fail++;
            $display("FAIL max_misses: gc=%0d sA=%0d ro=%b, required gc=7 sA=1 ro=1",
                     bus.guess_count, bus.scoreA, bus.round_over);
        end
    endtask

    task automatic test_b_wins_game();
        bit rd, gd;
        init_game(1'b1);
        code_phase();
        guess_phase(3'd4, rd);
        round_end_phase(gd);
        code_phase();
        for (int i = 0; i < MAXG; i++) guess_phase(3'd6, rd);
        round_end_phase(gd);
        n_checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.scoreB !== 2'd2) begin
            n_fail++;
            $display("FAIL b_wins: go=%b w=%b sB=%0d, required go=1 w=0 sB=2",
                     bus.game_over, bus.winner, bus.scoreB);
        end
    endtask

    task automatic test_reset_during_load();
        init_game(1'b0);
        code_phase();
        press(1'b1, 1'b0);
        bus.exact = 3'd4;
        reset     = 1'b0;
        #1;
        n_checks++;
        if ({bus.load_code, bus.load_guess, bus.active_p, bus.guess_count, bus.scoreA,
             bus.scoreB, bus.round_over, bus.game_over, bus.winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_in_load: lg=%b sA=%0d sB=%0d, required all outputs 0",
                     bus.load_guess, bus.scoreA, bus.scoreB);
        end
        bus.started = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.active_p !== 1'b0 || bus.scoreA !== 2'd0 || bus.round_over !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ap=%b sA=%0d ro=%b, required 0 0 0",
                     bus.active_p, bus.scoreA, bus.round_over);
        end
        bus.started = 1'b1;
        bus.first_p = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.active_p !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_code: ap=%b required 1", bus.active_p);
        end
    endtask

    task automatic test_random_games();
        bit rd, gd;
        logic [2:0] ex;
        for (int g = 0; g < 8; g++) begin
            init_game(1'($urandom_range(0, 1)));
            gd = 1'b0;
            for (int r = 0; r < 8 && !gd; r++) begin
                code_phase();
                rd = 1'b0;
                for (int i = 0; i < MAXG && !rd; i++) begin
                    ex = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
                    guess_phase(ex, rd);
                end
                round_end_phase(gd);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hit();
        test_max_misses();
        test_b_wins_game();
        test_reset_during_load();
        test_random_games();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
